// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master modport is the controller. The slave modport is the datapath side.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath (lw/sw/R-type/beq/addi/j).
// Define MC_BNE_EN to add bne support through the BNEEX state.
module mc_controller (
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // rtype marks the one state whose ALU op comes from funct instead of a constant.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       rtype;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_e s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALU_ADD;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.rtype   = 1'b1;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALU_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                c.alusrca  = 1'b1;
                c.aluop    = ALU_SUB;
                c.pcsrc    = 2'b01;
                c.branchne = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] alu_from_funct(logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100000: a = ALU_ADD;
            6'b100010: a = ALU_SUB;
            6'b100100: a = ALU_AND;
            6'b100101: a = ALU_OR;
            6'b101010: a = ALU_SLT;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q;

    // op is only looked at in DECODE and MEMADR; every other state has a fixed successor.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are registered alongside the state, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    // Write enables are masked by reset directly so nothing architectural commits while held.
    assign bus.pcen       = ~reset & (ctrl_q.pcwrite
                                      | (ctrl_q.branch   &  bus.zero)
                                      | (ctrl_q.branchne & ~bus.zero));
    assign bus.memwrite   = ~reset & ctrl_q.memwrite;
    assign bus.irwrite    = ~reset & ctrl_q.irwrite;
    assign bus.regwrite   = ~reset & ctrl_q.regwrite;
    assign bus.alusrca    = ctrl_q.alusrca;
    assign bus.iord       = ctrl_q.iord;
    assign bus.memtoreg   = ctrl_q.memtoreg;
    assign bus.regdst     = ctrl_q.regdst;
    assign bus.alusrcb    = ctrl_q.alusrcb;
    assign bus.pcsrc      = ctrl_q.pcsrc;
    assign bus.alucontrol = ctrl_q.rtype ? alu_from_funct(bus.funct) : ctrl_q.aluop;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller: per-cycle state and control outputs.
// Expected vector layout: {state, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol}.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] outs;
        string       name;
    } vec_t;

    // {pcen,memwrite,irwrite,regwrite, alusrca,iord,memtoreg,regdst, alusrcb, pcsrc, alucontrol}
    localparam logic [14:0] O_FETCH = 15'b1010_0000_01_00_010;
    localparam logic [14:0] O_RST   = 15'b0000_0000_01_00_010;
    localparam logic [14:0] O_DEC   = 15'b0000_0000_11_00_010;
    localparam logic [14:0] O_MADR  = 15'b0000_1000_10_00_010;
    localparam logic [14:0] O_MRD   = 15'b0000_0100_00_00_010;
    localparam logic [14:0] O_MWB   = 15'b0001_0010_00_00_010;
    localparam logic [14:0] O_MWR   = 15'b0100_0100_00_00_010;
    localparam logic [14:0] O_MWR_R = 15'b0000_0100_00_00_010;
    localparam logic [14:0] O_RTWB  = 15'b0001_0001_00_00_010;
    localparam logic [14:0] O_BR_T  = 15'b1000_1000_00_01_110;
    localparam logic [14:0] O_BR_N  = 15'b0000_1000_00_01_110;
    localparam logic [14:0] O_AWB   = 15'b0001_0000_00_00_010;
    localparam logic [14:0] O_J     = 15'b1000_0000_00_10_010;

    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [5:0]  fn_tab[6];
    logic [2:0]  alu_tab[6];

    function automatic logic [14:0] rtex(logic [2:0] alu);
        return {8'b0000_1000, 2'b00, 2'b00, alu};
    endfunction

    task automatic add(input string n, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input logic [3:0] st, input logic [14:0] o);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.funct = fn; v.zero = z;
        v.st = st; v.outs = o;
        vecs.push_back(v);
    endtask

    function automatic logic [18:0] actual();
        return {bus.state, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
                bus.alusrcb, bus.pcsrc, bus.alucontrol};
    endfunction

    task automatic check(input string name);
        logic [18:0] e;
        logic [18:0] a;
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s: got %b expected %b", name, a, e);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise.
    task automatic drive(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        #1;
        exp_q.push_back({v.st, v.outs});
        check(v.name);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        reset     = 1'b1;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        fn_tab  = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
        alu_tab = '{3'b111,    3'b010,    3'b110,    3'b000,    3'b001,    3'b010};

        // Reset held two cycles: FETCH state, all write enables masked.
        repeat (2) @(posedge clk);
        add("reset_hold", 1'b1, 6'b100011, 6'b0, 1'b0, 4'd0, O_RST);
        run_vecs();

        // lw, with op scrambled after MEMADR to show it is ignored there.
        add("lw_fetch",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("lw_decode", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd1, O_DEC);
        add("lw_memadr", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd2, O_MADR);
        add("lw_memrd",  1'b0, 6'b000010, 6'b0, 1'b1, 4'd3, O_MRD);
        add("lw_memwb",  1'b0, 6'b000010, 6'b0, 1'b0, 4'd4, O_MWB);
        // sw
        add("sw_fetch",  1'b0, 6'b101011, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("sw_decode", 1'b0, 6'b101011, 6'b0, 1'b0, 4'd1, O_DEC);
        add("sw_memadr", 1'b0, 6'b101011, 6'b0, 1'b0, 4'd2, O_MADR);
        add("sw_memwr",  1'b0, 6'b111111, 6'b0, 1'b0, 4'd5, O_MWR);
        // R-type for every funct code plus one unknown funct
        for (int i = 0; i < 6; i++) begin
            add($sformatf("rt%0d_fetch", i),  1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd0, O_FETCH);
            add($sformatf("rt%0d_decode", i), 1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd1, O_DEC);
            add($sformatf("rt%0d_ex", i),     1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd6, rtex(alu_tab[i]));
            add($sformatf("rt%0d_wb", i),     1'b0, 6'b100011, fn_tab[i], 1'b0, 4'd7, O_RTWB);
        end
        // beq taken / not taken
        add("beqt_fetch",  1'b0, 6'b000100, 6'b0, 1'b1, 4'd0, O_FETCH);
        add("beqt_decode", 1'b0, 6'b000100, 6'b0, 1'b1, 4'd1, O_DEC);
        add("beqt_ex",     1'b0, 6'b000100, 6'b0, 1'b1, 4'd8, O_BR_T);
        add("beqn_fetch",  1'b0, 6'b000100, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("beqn_decode", 1'b0, 6'b000100, 6'b0, 1'b0, 4'd1, O_DEC);
        add("beqn_ex",     1'b0, 6'b000100, 6'b0, 1'b0, 4'd8, O_BR_N);
        // addi
        add("addi_fetch",  1'b0, 6'b001000, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("addi_decode", 1'b0, 6'b001000, 6'b0, 1'b0, 4'd1, O_DEC);
        add("addi_ex",     1'b0, 6'b001000, 6'b0, 1'b0, 4'd9, O_MADR);
        add("addi_wb",     1'b0, 6'b101011, 6'b0, 1'b0, 4'd10, O_AWB);
        // j
        add("j_fetch",  1'b0, 6'b000010, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("j_decode", 1'b0, 6'b000010, 6'b0, 1'b0, 4'd1, O_DEC);
        add("j_ex",     1'b0, 6'b000010, 6'b0, 1'b0, 4'd11, O_J);
        // bne
        add("bne_fetch",  1'b0, 6'b000101, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("bne_decode", 1'b0, 6'b000101, 6'b0, 1'b0, 4'd1, O_DEC);
`ifdef MC_BNE_EN
        add("bnet_ex",     1'b0, 6'b000101, 6'b0, 1'b0, 4'd12, O_BR_T);
        add("bnen_fetch",  1'b0, 6'b000101, 6'b0, 1'b1, 4'd0, O_FETCH);
        add("bnen_decode", 1'b0, 6'b000101, 6'b0, 1'b1, 4'd1, O_DEC);
        add("bnen_ex",     1'b0, 6'b000101, 6'b0, 1'b1, 4'd12, O_BR_N);
`endif
        // illegal opcode behaves as a two-cycle NOP
        add("ill_fetch",  1'b0, 6'b111111, 6'b0, 1'b1, 4'd0, O_FETCH);
        add("ill_decode", 1'b0, 6'b111111, 6'b0, 1'b1, 4'd1, O_DEC);
        add("ill_back",   1'b0, 6'b111111, 6'b0, 1'b1, 4'd0, O_FETCH);
        run_vecs();

        // Reset arriving mid-store: memwrite masked at once, FETCH on the next edge.
        add("rs_decode",   1'b0, 6'b101011, 6'b0, 1'b0, 4'd1, O_DEC);
        add("rs_memadr",   1'b0, 6'b101011, 6'b0, 1'b0, 4'd2, O_MADR);
        add("rs_memwr",    1'b1, 6'b101011, 6'b0, 1'b0, 4'd5, O_MWR_R);
        add("rs_held",     1'b1, 6'b101011, 6'b0, 1'b0, 4'd0, O_RST);
        add("rs_release",  1'b0, 6'b101011, 6'b0, 1'b0, 4'd0, O_FETCH);
        add("rs_decode2",  1'b0, 6'b101011, 6'b0, 1'b0, 4'd1, O_DEC);
        run_vecs();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field, from the datapath instruction register.
REQ-005 funct  input  6  R-type function field, from the instruction register.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcen  output  1  PC register write enable.
REQ-008 memwrite  output  1  shared instruction/data memory write enable.
REQ-009 irwrite  output  1  instruction register write enable.
REQ-010 regwrite  output  1  register file write enable.
REQ-011 alusrca  output  1  ALU A select: 0=PC, 1=register A.
REQ-012 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-013 memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data.
REQ-014 regdst  output  1  destination register select: 0=rt, 1=rd.
REQ-015 alusrcb  output  2  ALU B select: 00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
REQ-016 pcsrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-017 alucontrol  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-018 state  output  4  current FSM state, for the debug display mux.

Function
REQ-019 The FSM SHALL be Moore with these 4-bit state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
REQ-020 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR on lw(100011) or sw(101011).
- DECODE->RTYPEEX on 000000.
- DECODE->BEQEX on 000100.
- DECODE->ADDIEX on 001000.
- DECODE->JEX on 000010.
- DECODE->FETCH on any other opcode (illegal op executes as a NOP).
- MEMADR->MEMRD on lw, MEMADR->MEMWR on sw.
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX and JEX->FETCH.
- Unused encodings->FETCH.
REQ-021 Per-state outputs SHALL be as follows; any output not listed is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, alu add.
- DECODE: alusrcb=11, alu add.
- MEMADR: alusrca=1, alusrcb=10, alu add.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, alucontrol decoded from funct.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, alu sub, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10, alu add.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
- BNEEX: as BEQEX, but asserts branchne=1 instead of branch.
REQ-022 pcen SHALL equal pcwrite | (branch & zero) | (branchne & ~zero), combinationally within the same cycle.
REQ-023 funct decode SHALL map 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL give 010.
REQ-024 alucontrol SHALL be 010 in every state except RTYPEEX, BEQEX and BNEEX.
REQ-025 Cycle counts from FETCH back to FETCH SHALL be:
- lw: 5.
- sw, R-type, addi: 4.
- beq, bne, j: 3.
- illegal op: 2.
REQ-026 op and funct SHALL be sampled only in DECODE, MEMADR and RTYPEEX; changes elsewhere SHALL have no effect.

Reset
REQ-027 On a rising edge with reset=1, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-028 While reset=1, pcen, memwrite, irwrite and regwrite SHALL be forced to 0 combinationally, so that no architectural write occurs.
REQ-029 The first cycle after reset deasserts SHALL be FETCH, with pcen=1 and irwrite=1.

Configuration
REQ-030 Macro MC_BNE_EN SHALL control bne support.
- Defined: DECODE on op 000101 SHALL go to BNEEX.
- Undefined: op 000101 SHALL be illegal (DECODE->FETCH), and BNEEX SHALL be an unused encoding.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset held 2 cycles, then op=100011 -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4.
- op=000000, funct=101010 -> alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7; no memwrite in any state.
- op=000100: zero=1 in state 8 -> pcen=1 and pcsrc=01; with zero=0 -> pcen=0; both cases return to state 0.
- op=000101 with MC_BNE_EN defined and zero=0 -> state 12, pcen=1; with MC_BNE_EN undefined -> sequence 0,1,0, with no write enables in state 1.
- reset asserted while in MEMWR (state 5) -> memwrite=0 in that cycle; state=0 on the next edge.
- op=111111 (illegal) -> sequence 0,1,0; pcen asserted only in FETCH.
